// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit path.
// The baud divider is fixed here so scheduler and transmitter agree on frame timing.
package uart_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned CLK_HZ   = 50_000_000;
   localparam int unsigned BAUD     = 115_200;
   localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;

   typedef enum logic [2:0] {
      StIdle,
      StArb,
      StSend,
      StStart,
      StWaitBusy,
      StWaitDone,
      StRelease
   } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned IdW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IdW-1:0]     ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IdW-1:0]     idx,
   output logic               any
);

   logic [IdW-1:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IdW'((32'(ptr) + k) % NUM_REQ);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Packet-granular round-robin sharing of one UART byte transmitter between NUM_REQ streams.
// Each byte is paced on the transmitter's start/busy handshake; only one byte is ever in flight.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter  int unsigned NUM_REQ      = 2,
   parameter  int unsigned DATA_W       = uart_pkg::DATA_W,
   parameter  int unsigned MAX_BURST    = 16,
   parameter  int unsigned BUSY_TIMEOUT = 8,
   localparam int unsigned IdW          = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_start,
   input  logic                      tx_busy,
   output logic [IdW-1:0]            grant_id,
   output logic                      active,
   output logic                      timeout_err
);

   localparam bit          BurstEn    = (MAX_BURST != 0);
   localparam int unsigned BurstW     = $clog2(MAX_BURST + 2);
   localparam int unsigned BurstLastI = BurstEn ? MAX_BURST - 1 : 0;
   localparam int unsigned TimerW     = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [BurstW-1:0] BurstLast = BurstW'(BurstLastI);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(BUSY_TIMEOUT - 1);
   localparam logic [IdW-1:0]    IdMax     = IdW'(NUM_REQ - 1);

   sched_state_e      state;
   logic [IdW-1:0]    ptr;
   logic [BurstW-1:0] burst_cnt;
   logic [TimerW-1:0] timer;
   logic              last_flag;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IdW-1:0]     arb_idx;
   logic               arb_any;
   logic [DATA_W-1:0]  sel_data;
   logic               burst_hit;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req (req_valid),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign sel_data  = req_data[grant_id*DATA_W +: DATA_W];
   assign burst_hit = BurstEn && (burst_cnt == BurstLast);

   // Ready is the acceptance strobe itself, so it must follow valid within the SEND cycle.
   assign req_ready = (state == StSend) ? (req_valid & (NUM_REQ'(1) << grant_id)) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StIdle;
         ptr         <= '0;
         burst_cnt   <= '0;
         timer       <= '0;
         last_flag   <= 1'b0;
         tx_data     <= '0;
         tx_start    <= 1'b0;
         grant_id    <= '0;
         active      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         tx_start    <= 1'b0;
         timeout_err <= 1'b0;
         unique case (state)
            StIdle: begin
               if (|req_valid) state <= StArb;
            end
            StArb: begin
               if (arb_any) begin
                  grant_id  <= arb_idx;
                  active    <= 1'b1;
                  burst_cnt <= '0;
                  state     <= StSend;
               end else begin
                  state <= StIdle;
               end
            end
            StSend: begin
               // A stalled owner keeps the grant: packets are never interleaved.
               if (req_valid[grant_id]) begin
                  tx_data   <= sel_data;
                  last_flag <= req_last[grant_id] | burst_hit;
                  if (BurstEn) burst_cnt <= burst_cnt + 1'b1;
                  tx_start  <= 1'b1;
                  state     <= StStart;
               end
            end
            StStart: begin
               // Timer counts cycles since the tx_start pulse.
               timer <= TimerW'(1);
               state <= StWaitBusy;
            end
            StWaitBusy: begin
               if (tx_busy) begin
                  state <= StWaitDone;
               end else if (timer == TimerLast) begin
                  timeout_err <= 1'b1;
                  state       <= last_flag ? StRelease : StSend;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            StWaitDone: begin
               if (!tx_busy) state <= last_flag ? StRelease : StSend;
            end
            StRelease: begin
               active <= 1'b0;
               ptr    <= (grant_id == IdMax) ? '0 : grant_id + 1'b1;
               state  <= (|req_valid) ? StArb : StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: requester queues, a busy-pulse transmitter model,
// and hand-written expected byte orders.
module tb_uart_tx_scheduler;

   localparam int unsigned NR       = 2;
   localparam int unsigned DW       = 8;
   localparam int          BUSY_LEN = 20;

   logic          clk;
   logic          reset;
   logic [NR-1:0] req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0] req_last;
   logic [NR-1:0] req_ready;
   logic [DW-1:0] tx_data;
   logic          tx_start;
   logic          tx_busy;
   logic          grant_id;
   logic          active;
   logic          timeout_err;

   uart_tx_scheduler #(
      .NUM_REQ      (NR),
      .DATA_W       (DW),
      .MAX_BURST    (4),
      .BUSY_TIMEOUT (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .grant_id    (grant_id),
      .active      (active),
      .timeout_err (timeout_err)
   );

   int n_tot = 0;
   int n_bad = 0;
   int cyc   = 0;

   // {last, byte} per requester; {grant_id, byte} per transmitted frame
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] txq[$];
   logic [8:0] expq[$];
   int         tx_cyc[$];
   int         to_cyc[$];

   logic [NR-1:0] hold     = '0;
   logic [NR-1:0] acc_pend = '0;
   int            acc_cnt[NR];
   int            acc_last_cyc[NR];
   int            fv_cyc[NR];
   int            start_while_busy = 0;
   int            onehot_viol = 0;
   int            busy_cnt = 0;
   bit            busy_mode = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever @(posedge clk) cyc++;

   // Requester driver: presents queue fronts, pops after an observed acceptance.
   initial begin
      logic [NR-1:0] prev_valid;
      logic [8:0]    f;
      prev_valid = '0;
      req_valid  = '0;
      req_data   = '0;
      req_last   = '0;
      for (int i = 0; i < NR; i++) begin
         acc_cnt[i] = 0;
         acc_last_cyc[i] = 0;
         fv_cyc[i] = 0;
      end
      forever begin
         @(negedge clk);
         if (acc_pend[0]) void'(q0.pop_front());
         if (acc_pend[1]) void'(q1.pop_front());
         req_valid[0] = (q0.size() > 0) && !hold[0];
         req_valid[1] = (q1.size() > 0) && !hold[1];
         f = (q0.size() > 0) ? q0[0] : 9'h0;
         req_data[7:0] = f[7:0];
         req_last[0]   = f[8];
         f = (q1.size() > 0) ? q1[0] : 9'h0;
         req_data[15:8] = f[7:0];
         req_last[1]    = f[8];
         for (int i = 0; i < NR; i++)
            if (req_valid[i] && !prev_valid[i]) fv_cyc[i] = cyc;
         prev_valid = req_valid;
         #1;
         if (req_ready == 2'b11) onehot_viol++;
         for (int i = 0; i < NR; i++) begin
            acc_pend[i] = req_ready[i] & req_valid[i] & !reset;
            if (acc_pend[i]) begin
               acc_cnt[i]++;
               acc_last_cyc[i] = cyc;
            end
         end
      end
   end

   // Transmitter model: logs each tx_start and, in busy mode, stays busy BUSY_LEN cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            tx_busy  = 1'b0;
            busy_cnt = 0;
         end else begin
            if (busy_cnt > 0) begin
               busy_cnt--;
               if (busy_cnt == 0) tx_busy = 1'b0;
            end
            if (tx_start) begin
               if (tx_busy) start_while_busy++;
               txq.push_back({grant_id, tx_data});
               tx_cyc.push_back(cyc);
               if (busy_mode) begin
                  tx_busy  = 1'b1;
                  busy_cnt = BUSY_LEN;
               end
            end
            if (timeout_err) to_cyc.push_back(cyc);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_idle(input string tag);
      int stable = 0;
      int n = 0;
      while (stable < 3 && n < 3000) begin
         step();
         n++;
         if (q0.size() == 0 && q1.size() == 0 && !active && !tx_busy) stable++;
         else stable = 0;
      end
      chk({tag, "_idle"}, stable, 3);
   endtask

   task automatic wait_acc(input int r, input int target, input string tag);
      int n = 0;
      while (acc_cnt[r] < target && n < 2000) begin
         step();
         n++;
      end
      chk({tag, "_acc"}, acc_cnt[r], target);
   endtask

   task automatic check_tx(input string tag);
      chk($sformatf("%s_len", tag), txq.size(), expq.size());
      for (int k = 0; k < expq.size() && k < txq.size(); k++)
         chk($sformatf("%s_b%0d", tag, k), txq[k], expq[k]);
      txq.delete();
      expq.delete();
      tx_cyc.delete();
      to_cyc.delete();
   endtask

   initial begin
      int gap_r1;
      reset = 1'b1;
      repeat (3) step();
      chk("rst_ready", req_ready, 0);
      chk("rst_start", tx_start, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_active", active, 0);
      chk("rst_toerr", timeout_err, 0);

      // Both requesters pending at reset release: pointer 0 wins, packets not interleaved.
      q0.push_back(9'h011); q0.push_back(9'h112);
      q1.push_back(9'h021); q1.push_back(9'h122);
      step();
      reset = 1'b0;
      expq = '{9'h011, 9'h012, 9'h121, 9'h122};
      wait_idle("t2");
      check_tx("t2");

      // Single requester, three bytes.
      q0.push_back(9'h0A5); q0.push_back(9'h03C); q0.push_back(9'h1FF);
      wait_acc(0, acc_cnt[0] + 1, "t1");
      chk("t1_active", active, 1);
      chk("t1_gid", grant_id, 0);
      expq = '{9'h0A5, 9'h03C, 9'h0FF};
      wait_idle("t1");
      chk("t1_active_drop", active, 0);
      check_tx("t1");

      // Pointer now 1: simultaneous requests serve r1 first.
      q0.push_back(9'h101);
      q1.push_back(9'h102);
      expq = '{9'h102, 9'h001};
      wait_idle("ptr");
      check_tx("ptr");

      // Burst limit 4 forces rearbitration mid-packet.
      for (int k = 0; k < 6; k++) q0.push_back({(k == 5), 8'(8'h40 + k)});
      wait_acc(0, acc_cnt[0] + 1, "t3");
      q1.push_back(9'h031); q1.push_back(9'h132);
      expq = '{9'h040, 9'h041, 9'h042, 9'h043, 9'h131, 9'h132, 9'h044, 9'h045};
      wait_idle("t3");
      check_tx("t3");

      // Owner stalls mid-packet; r1 must not be served during the gap.
      q0.push_back(9'h050); q0.push_back(9'h051); q0.push_back(9'h152);
      wait_acc(0, acc_cnt[0] + 1, "t4");
      hold[0] = 1'b1;
      q1.push_back(9'h160);
      gap_r1 = 0;
      repeat (40) begin
         step();
         if (req_ready[1]) gap_r1++;
      end
      chk("t4_gap_r1", gap_r1, 0);
      chk("t4_gap_active", active, 1);
      hold[0] = 1'b0;
      expq = '{9'h050, 9'h051, 9'h052, 9'h160};
      wait_idle("t4");
      check_tx("t4");

      // Transmitter never goes busy: timeout 8 cycles after each start, then carry on.
      busy_mode = 1'b0;
      q0.push_back(9'h070); q0.push_back(9'h171);
      repeat (60) step();
      chk("t5_to_cnt", to_cyc.size(), 2);
      chk("t5_tx_cnt", tx_cyc.size(), 2);
      if (to_cyc.size() == 2 && tx_cyc.size() == 2) begin
         chk("t5_to0_lat", to_cyc[0] - tx_cyc[0], 8);
         chk("t5_to1_lat", to_cyc[1] - tx_cyc[1], 8);
         chk("t5_spacing", tx_cyc[1] - tx_cyc[0], 9);
      end
      expq = '{9'h070, 9'h071};
      wait_idle("t5");
      check_tx("t5");
      busy_mode = 1'b1;

      // Reset during WAIT_DONE, then a fresh single-byte packet.
      q1.push_back(9'h180);
      begin
         int n = 0;
         while (!tx_busy && n < 200) begin
            step();
            n++;
         end
      end
      chk("t6_busy_seen", tx_busy, 1);
      repeat (3) step();
      chk("t6_pre_gid", grant_id, 1);
      chk("t6_pre_active", active, 1);
      reset = 1'b1;
      step();
      chk("t6_rst_ready", req_ready, 0);
      chk("t6_rst_start", tx_start, 0);
      chk("t6_rst_data", tx_data, 0);
      chk("t6_rst_gid", grant_id, 0);
      chk("t6_rst_active", active, 0);
      chk("t6_rst_toerr", timeout_err, 0);
      reset = 1'b0;
      txq.delete();
      tx_cyc.delete();
      step();
      q0.push_back(9'h155);
      expq = '{9'h055};
      wait_idle("t6");
      chk("t6_ready_lat", acc_last_cyc[0] - fv_cyc[0], 2);
      check_tx("t6");

      chk("start_while_busy", start_while_busy, 0);
      chk("ready_onehot", onehot_viol, 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
